// File: rtl/rs_issue_queue_pkg.sv
// Shared widths and record types for the unified reservation station.
// Counts that scale the queue (depth, lanes, wake ports) stay as top-level parameters.
package rs_issue_queue_pkg;

  localparam int ISSUE_W   = 3;
  localparam int FU_W      = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam int PREG_W    = 6;
  localparam int ROB_W     = 4;
  localparam int DATA_W    = 32;
  localparam int PAYLOAD_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [FU_W-1:0]      fu;
    logic [ROB_W-1:0]     rob;
    logic [PREG_W-1:0]    s1tag;
    logic                 s1rdy;
    logic [DATA_W-1:0]    s1val;
    logic [PREG_W-1:0]    s2tag;
    logic                 s2rdy;
    logic [DATA_W-1:0]    s2val;
    logic [PAYLOAD_W-1:0] payload;
  } rsEntryStruct;

  typedef struct packed {
    logic                 valid;
    logic [FU_W-1:0]      fu;
    logic [ROB_W-1:0]     rob;
    logic [PREG_W-1:0]    s1tag;
    logic                 s1rdy;
    logic [DATA_W-1:0]    s1val;
    logic [PREG_W-1:0]    s2tag;
    logic                 s2rdy;
    logic [DATA_W-1:0]    s2val;
    logic [PAYLOAD_W-1:0] payload;
  } rsDispatchLaneStruct;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] tag;
    logic [DATA_W-1:0] val;
  } wakePortStruct;

  typedef struct packed {
    logic                 valid;
    logic [ROB_W-1:0]     rob;
    logic [DATA_W-1:0]    s1val;
    logic [DATA_W-1:0]    s2val;
    logic [PAYLOAD_W-1:0] payload;
  } rsIssueStruct;

endpackage

// File: rtl/rs_oldest_picker.sv
// Age tracking for the reservation station: one shared age matrix plus a per-FU oldest picker.
// ageMat[i][j]=1 means entry j is older than entry i.
module rs_age_matrix #(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [DEPTH-1:0]             allocVec,
  input  logic [DEPTH-1:0][DEPTH-1:0]  allocRows,
  input  logic [DEPTH-1:0]             freeVec,
  output logic [DEPTH-1:0][DEPTH-1:0]  ageMat
);

  // A new row records everything older at allocation; a freed entry drops out of every row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ageMat <= '0;
    end else if (flush) begin
      ageMat <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (allocVec[i]) begin
            ageMat[i][j] <= allocRows[i][j] && !freeVec[j];
          end else if (freeVec[j]) begin
            ageMat[i][j] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

module rs_oldest_picker #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0][DEPTH-1:0] ageMat,
  input  logic [DEPTH-1:0]            req,
  output logic [DEPTH-1:0]            gnt
);

  // A requester wins when no other requester is older than it.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      gnt[i] = req[i] && ((ageMat[i] & req) == '0);
    end
  end

endmodule

// File: rtl/rs_issue_queue.sv
// Unified reservation station: captures operands from wake ports and issues the oldest ready entry per FU.
// Registered issue one edge after operands become ready; dispatch is all-or-none against the free count.
module rs_issue_queue
  import rs_issue_queue_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int WAKE_W     = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [DISPATCH_W-1:0]           disp_valid,
  output logic                            disp_ready,
  input  logic [DISPATCH_W*FU_W-1:0]      disp_fu,
  input  logic [DISPATCH_W*ROB_W-1:0]     disp_rob,
  input  logic [DISPATCH_W*PREG_W-1:0]    disp_s1_tag,
  input  logic [DISPATCH_W-1:0]           disp_s1_rdy,
  input  logic [DISPATCH_W*DATA_W-1:0]    disp_s1_val,
  input  logic [DISPATCH_W*PREG_W-1:0]    disp_s2_tag,
  input  logic [DISPATCH_W-1:0]           disp_s2_rdy,
  input  logic [DISPATCH_W*DATA_W-1:0]    disp_s2_val,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload,
  input  logic [WAKE_W-1:0]               wake_valid,
  input  logic [WAKE_W*PREG_W-1:0]        wake_tag,
  input  logic [WAKE_W*DATA_W-1:0]        wake_val,
  input  logic [ISSUE_W-1:0]              fu_ready,
  output logic [ISSUE_W-1:0]              iss_valid,
  output logic [ISSUE_W*ROB_W-1:0]        iss_rob,
  output logic [ISSUE_W*DATA_W-1:0]       iss_s1_val,
  output logic [ISSUE_W*DATA_W-1:0]       iss_s2_val,
  output logic [ISSUE_W*PAYLOAD_W-1:0]    iss_payload,
  output logic [$clog2(DEPTH):0]          free_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rsDispatchLaneStruct        lane     [DISPATCH_W];
  wakePortStruct              wake     [WAKE_W];
  rsEntryStruct               entry    [DEPTH];
  rsEntryStruct               entryNext[DEPTH];
  rsEntryStruct               newEnt   [DISPATCH_W];
  rsIssueStruct               issNext  [ISSUE_W];
  rsIssueStruct               issReg   [ISSUE_W];
  logic [DEPTH-1:0]           validVec;
  logic [DEPTH-1:0]           freeVec;
  logic [DEPTH-1:0]           allocVec;
  logic [DEPTH-1:0]           taken;
  logic [DEPTH-1:0][DEPTH-1:0] allocRows;
  logic [DEPTH-1:0][DEPTH-1:0] ageMat;
  logic [DEPTH-1:0]           reqVec   [ISSUE_W];
  logic [DEPTH-1:0]           gntVec   [ISSUE_W];
  logic [IDX_W-1:0]           laneSlot [DISPATCH_W];
  logic [DISPATCH_W-1:0]      laneGo;
  logic                       slotFound;
  logic                       dispAccept;
  logic [CNT_W-1:0]           freeCnt;
  logic [CNT_W-1:0]           nAlloc;
  logic [CNT_W-1:0]           nFree;

  always_comb begin
    for (int l = 0; l < DISPATCH_W; l++) begin
      lane[l].valid   = disp_valid[l];
      lane[l].fu      = disp_fu[l*FU_W +: FU_W];
      lane[l].rob     = disp_rob[l*ROB_W +: ROB_W];
      lane[l].s1tag   = disp_s1_tag[l*PREG_W +: PREG_W];
      lane[l].s1rdy   = disp_s1_rdy[l];
      lane[l].s1val   = disp_s1_val[l*DATA_W +: DATA_W];
      lane[l].s2tag   = disp_s2_tag[l*PREG_W +: PREG_W];
      lane[l].s2rdy   = disp_s2_rdy[l];
      lane[l].s2val   = disp_s2_val[l*DATA_W +: DATA_W];
      lane[l].payload = disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
    end
    for (int w = 0; w < WAKE_W; w++) begin
      wake[w].valid = wake_valid[w];
      wake[w].tag   = wake_tag[w*PREG_W +: PREG_W];
      wake[w].val   = wake_val[w*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      validVec[i] = entry[i].valid;
    end
  end

  assign disp_ready = freeCnt >= CNT_W'(DISPATCH_W);
  assign dispAccept = disp_ready && (|disp_valid) && !flush;

  // Select: per FU, requesters are ready entries targeting it.
  always_comb begin
    for (int f = 0; f < ISSUE_W; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        reqVec[f][i] = fu_ready[f] && entry[i].valid && (entry[i].fu == FU_W'(f)) &&
                       entry[i].s1rdy && entry[i].s2rdy;
      end
    end
  end

  for (genvar f = 0; f < ISSUE_W; f++) begin : gPick
    rs_oldest_picker #(.DEPTH(DEPTH)) uPick (
      .ageMat (ageMat),
      .req    (reqVec[f]),
      .gnt    (gntVec[f])
    );
  end

  always_comb begin
    freeVec = '0;
    for (int f = 0; f < ISSUE_W; f++) begin
      freeVec = freeVec | gntVec[f];
      issNext[f] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (gntVec[f][i]) begin
          issNext[f].valid   = 1'b1;
          issNext[f].rob     = entry[i].rob;
          issNext[f].s1val   = entry[i].s1val;
          issNext[f].s2val   = entry[i].s2val;
          issNext[f].payload = entry[i].payload;
        end
      end
    end
  end

  // Lanes claim the lowest free slots of the pre-edge free set; slots freed this edge stay out.
  always_comb begin
    taken     = validVec;
    allocVec  = '0;
    allocRows = '0;
    laneGo    = '0;
    slotFound = 1'b0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      laneSlot[l] = '0;
      slotFound   = 1'b0;
      if (dispAccept && lane[l].valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!slotFound && !taken[i]) begin
            slotFound   = 1'b1;
            laneSlot[l] = IDX_W'(i);
          end
        end
        if (slotFound) begin
          laneGo[l]             = 1'b1;
          allocVec[laneSlot[l]] = 1'b1;
          allocRows[laneSlot[l]] = taken;
          taken[laneSlot[l]]    = 1'b1;
        end
      end
    end
  end

  // Descending port order leaves the lowest-numbered matching wake port as the winner.
  always_comb begin
    for (int l = 0; l < DISPATCH_W; l++) begin
      newEnt[l].valid   = 1'b1;
      newEnt[l].fu      = lane[l].fu;
      newEnt[l].rob     = lane[l].rob;
      newEnt[l].s1tag   = lane[l].s1tag;
      newEnt[l].s1rdy   = lane[l].s1rdy;
      newEnt[l].s1val   = lane[l].s1val;
      newEnt[l].s2tag   = lane[l].s2tag;
      newEnt[l].s2rdy   = lane[l].s2rdy;
      newEnt[l].s2val   = lane[l].s2val;
      newEnt[l].payload = lane[l].payload;
      for (int w = WAKE_W - 1; w >= 0; w--) begin
        if (!lane[l].s1rdy && wake[w].valid && wake[w].tag == lane[l].s1tag) begin
          newEnt[l].s1rdy = 1'b1;
          newEnt[l].s1val = wake[w].val;
        end
        if (!lane[l].s2rdy && wake[w].valid && wake[w].tag == lane[l].s2tag) begin
          newEnt[l].s2rdy = 1'b1;
          newEnt[l].s2val = wake[w].val;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entryNext[i] = entry[i];
      for (int w = WAKE_W - 1; w >= 0; w--) begin
        if (!entry[i].s1rdy && wake[w].valid && wake[w].tag == entry[i].s1tag) begin
          entryNext[i].s1rdy = 1'b1;
          entryNext[i].s1val = wake[w].val;
        end
        if (!entry[i].s2rdy && wake[w].valid && wake[w].tag == entry[i].s2tag) begin
          entryNext[i].s2rdy = 1'b1;
          entryNext[i].s2val = wake[w].val;
        end
      end
      if (freeVec[i]) begin
        entryNext[i].valid = 1'b0;
      end
      for (int l = 0; l < DISPATCH_W; l++) begin
        if (laneGo[l] && laneSlot[l] == IDX_W'(i)) begin
          entryNext[i] = newEnt[l];
        end
      end
      if (flush) begin
        entryNext[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    nAlloc = '0;
    nFree  = '0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      nAlloc = nAlloc + CNT_W'(laneGo[l]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      nFree = nFree + CNT_W'(freeVec[i]);
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) uAge (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .allocVec  (allocVec),
    .allocRows (allocRows),
    .freeVec   (freeVec),
    .ageMat    (ageMat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
      for (int f = 0; f < ISSUE_W; f++) begin
        issReg[f] <= '0;
      end
      freeCnt <= CNT_W'(DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= entryNext[i];
      end
      for (int f = 0; f < ISSUE_W; f++) begin
        issReg[f] <= flush ? '0 : issNext[f];
      end
      freeCnt <= flush ? CNT_W'(DEPTH) : (freeCnt - nAlloc + nFree);
    end
  end

  always_comb begin
    for (int f = 0; f < ISSUE_W; f++) begin
      iss_valid[f]                         = issReg[f].valid;
      iss_rob[f*ROB_W +: ROB_W]            = issReg[f].rob;
      iss_s1_val[f*DATA_W +: DATA_W]       = issReg[f].s1val;
      iss_s2_val[f*DATA_W +: DATA_W]       = issReg[f].s2val;
      iss_payload[f*PAYLOAD_W +: PAYLOAD_W] = issReg[f].payload;
    end
  end

  assign free_cnt = freeCnt;

  freeCntRange: assert property (@(posedge clk) disable iff (!rst_n) freeCnt <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_rs_issue_queue.sv
// Randomised and directed stimulus against an age-ordered queue model of the reservation station.
// Expected issues and per-cycle status are queued by the driver and consumed by a negedge monitor.
module tb_rs_issue_queue;

  localparam int DEPTH = 16;
  localparam int DW    = 2;
  localparam int WW    = 2;
  localparam int IW    = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  logic [DW-1:0]    disp_valid;
  logic             disp_ready;
  logic [DW*2-1:0]  disp_fu;
  logic [DW*4-1:0]  disp_rob;
  logic [DW*6-1:0]  disp_s1_tag, disp_s2_tag;
  logic [DW-1:0]    disp_s1_rdy, disp_s2_rdy;
  logic [DW*32-1:0] disp_s1_val, disp_s2_val, disp_payload;
  logic [WW-1:0]    wake_valid;
  logic [WW*6-1:0]  wake_tag;
  logic [WW*32-1:0] wake_val;
  logic [IW-1:0]    fu_ready;
  logic [IW-1:0]    iss_valid;
  logic [IW*4-1:0]  iss_rob;
  logic [IW*32-1:0] iss_s1_val, iss_s2_val, iss_payload;
  logic [4:0]       free_cnt;

  rs_issue_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu), .disp_rob(disp_rob),
    .disp_s1_tag(disp_s1_tag), .disp_s1_rdy(disp_s1_rdy), .disp_s1_val(disp_s1_val),
    .disp_s2_tag(disp_s2_tag), .disp_s2_rdy(disp_s2_rdy), .disp_s2_val(disp_s2_val),
    .disp_payload(disp_payload), .wake_valid(wake_valid), .wake_tag(wake_tag), .wake_val(wake_val),
    .fu_ready(fu_ready), .iss_valid(iss_valid), .iss_rob(iss_rob), .iss_s1_val(iss_s1_val),
    .iss_s2_val(iss_s2_val), .iss_payload(iss_payload), .free_cnt(free_cnt)
  );

  logic        dv [DW];
  logic [1:0]  dfu[DW];
  logic [3:0]  drob[DW];
  logic [5:0]  dt1[DW], dt2[DW];
  logic        dr1[DW], dr2[DW];
  logic [31:0] dv1[DW], dv2[DW], dpl[DW];
  logic        wv [WW];
  logic [5:0]  wt [WW];
  logic [31:0] wval[WW];

  always_comb begin
    for (int l = 0; l < DW; l++) begin
      disp_valid[l]          = dv[l];
      disp_fu[l*2 +: 2]      = dfu[l];
      disp_rob[l*4 +: 4]     = drob[l];
      disp_s1_tag[l*6 +: 6]  = dt1[l];
      disp_s2_tag[l*6 +: 6]  = dt2[l];
      disp_s1_rdy[l]         = dr1[l];
      disp_s2_rdy[l]         = dr2[l];
      disp_s1_val[l*32 +: 32] = dv1[l];
      disp_s2_val[l*32 +: 32] = dv2[l];
      disp_payload[l*32 +: 32] = dpl[l];
    end
    for (int w = 0; w < WW; w++) begin
      wake_valid[w]        = wv[w];
      wake_tag[w*6 +: 6]   = wt[w];
      wake_val[w*32 +: 32] = wval[w];
    end
  end

  typedef struct {
    logic [1:0]  fu;
    logic [3:0]  rob;
    logic [5:0]  t1, t2;
    logic        r1, r2;
    logic [31:0] v1, v2, pl;
  } mEnt_t;
  typedef struct {
    logic [3:0]  rob;
    logic [31:0] v1, v2, pl;
  } mIss_t;
  typedef struct {
    logic [IW-1:0] vld;
    int            freeN;
  } mCyc_t;

  mEnt_t mq[$];          // live entries, oldest first
  mIss_t expIss[IW][$];
  mCyc_t expCyc[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] seqNo = 32'h100;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void capt(input logic [5:0] t, inout logic r, inout logic [31:0] v);
    for (int w = 0; w < WW; w++) begin
      if (!r && wv[w] && wt[w] == t) begin
        r = 1'b1;
        v = wval[w];
      end
    end
  endfunction

  // Reference: one clock edge computed from the current inputs and the modelled contents.
  task automatic modelEdge();
    int    preFree;
    mCyc_t c;
    mEnt_t e;
    preFree = DEPTH - mq.size();
    chk("disp_ready", 64'(disp_ready), 64'(preFree >= DW));
    c.vld = '0;
    if (flush) begin
      mq.delete();
      c.freeN = DEPTH;
    end else begin
      for (int f = 0; f < IW; f++) begin
        int hit;
        hit = -1;
        if (fu_ready[f]) begin
          for (int k = 0; k < mq.size(); k++) begin
            if (hit < 0 && mq[k].fu == 2'(f) && mq[k].r1 && mq[k].r2) hit = k;
          end
        end
        if (hit >= 0) begin
          expIss[f].push_back('{rob: mq[hit].rob, v1: mq[hit].v1, v2: mq[hit].v2, pl: mq[hit].pl});
          c.vld[f] = 1'b1;
          mq.delete(hit);
        end
      end
      for (int k = 0; k < mq.size(); k++) begin
        e = mq[k];
        capt(e.t1, e.r1, e.v1);
        capt(e.t2, e.r2, e.v2);
        mq[k] = e;
      end
      if (preFree >= DW) begin
        for (int l = 0; l < DW; l++) begin
          if (dv[l]) begin
            e = '{fu: dfu[l], rob: drob[l], t1: dt1[l], t2: dt2[l], r1: dr1[l], r2: dr2[l],
                  v1: dv1[l], v2: dv2[l], pl: dpl[l]};
            capt(e.t1, e.r1, e.v1);
            capt(e.t2, e.r2, e.v2);
            mq.push_back(e);
          end
        end
      end
      c.freeN = DEPTH - mq.size();
    end
    expCyc.push_back(c);
  endtask

  always @(negedge clk) begin : monitor
    mCyc_t c;
    mIss_t e;
    if (expCyc.size() > 0) begin
      c = expCyc.pop_front();
      chk("iss_valid", 64'(iss_valid), 64'(c.vld));
      chk("free_cnt", 64'(free_cnt), 64'(c.freeN));
      for (int f = 0; f < IW; f++) begin
        if (c.vld[f] && expIss[f].size() > 0) begin
          e = expIss[f].pop_front();
          if (iss_valid[f]) begin
            chk("iss_rob", 64'(iss_rob[f*4 +: 4]), 64'(e.rob));
            chk("iss_s1_val", 64'(iss_s1_val[f*32 +: 32]), 64'(e.v1));
            chk("iss_s2_val", 64'(iss_s2_val[f*32 +: 32]), 64'(e.v2));
            chk("iss_payload", 64'(iss_payload[f*32 +: 32]), 64'(e.pl));
          end
        end
      end
    end
  end

  task automatic idle();
    flush = 1'b0;
    for (int l = 0; l < DW; l++) begin
      dv[l] = 1'b0; dfu[l] = '0; drob[l] = '0; dt1[l] = '0; dt2[l] = '0;
      dr1[l] = 1'b0; dr2[l] = 1'b0; dv1[l] = '0; dv2[l] = '0; dpl[l] = '0;
    end
    for (int w = 0; w < WW; w++) begin
      wv[w] = 1'b0; wt[w] = '0; wval[w] = '0;
    end
  endtask

  task automatic setLane(input int l, input int fu, input int t1, input logic r1,
                         input int t2, input logic r2);
    dv[l]   = 1'b1;
    dfu[l]  = 2'(fu);
    drob[l] = 4'($urandom);
    dt1[l]  = 6'(t1);
    dr1[l]  = r1;
    dv1[l]  = $urandom;
    dt2[l]  = 6'(t2);
    dr2[l]  = r2;
    dv2[l]  = $urandom;
    dpl[l]  = seqNo;
    seqNo   = seqNo + 1;
  endtask

  task automatic setWake(input int w, input int tag, input logic [31:0] val);
    wv[w] = 1'b1; wt[w] = 6'(tag); wval[w] = val;
  endtask

  task automatic step();
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic idleSteps(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle();
    mq.delete();
    expCyc.delete();
    for (int f = 0; f < IW; f++) expIss[f].delete();
    #7;
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_rob", 64'(iss_rob), 64'd0);
    chk("rst_free_cnt", 64'(free_cnt), 64'(DEPTH));
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
  endtask

  initial begin
    fu_ready = '0;
    doReset();

    // Two ready ops on FU0 and FU1.
    fu_ready = 3'b111;
    idle(); setLane(0, 0, 1, 1, 2, 1); setLane(1, 1, 3, 1, 4, 1); step();
    idleSteps(2);

    // Late wake on tag 5.
    idle(); setLane(0, 2, 5, 0, 6, 1); step();
    idleSteps(3);
    idle(); setWake(0, 5, 32'hDEAD); step();
    idleSteps(2);

    // Same-cycle wake bypass on tag 7, with a conflicting higher port.
    idle(); setLane(0, 1, 7, 0, 8, 1); setWake(1, 7, 32'h2222); setWake(0, 7, 32'h1111); step();
    idleSteps(2);

    // Fill to one free slot waiting on tag 9, then drain through FU0 only.
    fu_ready = 3'b000;
    for (int n = 0; n < 7; n++) begin
      idle(); setLane(0, (2*n) % 3, 9, 0, 1, 1); setLane(1, (2*n+1) % 3, 9, 0, 1, 1); step();
    end
    idle(); setLane(0, 0, 9, 0, 1, 1); step();
    idle(); setLane(0, 0, 2, 1, 3, 1); setLane(1, 1, 2, 1, 3, 1); step();
    fu_ready = 3'b001;
    idle(); setWake(0, 9, 32'h9999); step();
    idleSteps(7);
    fu_ready = 3'b111;
    idleSteps(6);

    // FU0 stalled while A, B, C wait.
    fu_ready = 3'b000;
    idle(); setLane(0, 0, 1, 1, 1, 1); setLane(1, 0, 2, 1, 2, 1); step();
    idle(); setLane(0, 0, 3, 1, 3, 1); step();
    idleSteps(2);
    fu_ready = 3'b111;
    idleSteps(4);

    // Flush alongside dispatch and a wake; the old tag later wakes nothing.
    fu_ready = 3'b000;
    for (int n = 0; n < 5; n++) begin
      idle(); setLane(0, n % 3, 12, 0, 1, 1); setLane(1, (n+1) % 3, 12, 0, 1, 1); step();
    end
    fu_ready = 3'b111;
    idle(); flush = 1'b1; setLane(0, 0, 1, 1, 1, 1); setWake(0, 12, 32'h1200); step();
    idleSteps(1);
    idle(); setWake(0, 12, 32'h1201); step();
    idleSteps(2);

    for (int pass = 0; pass < 2; pass++) begin
      for (int cyc = 0; cyc < 1200; cyc++) begin
        idle();
        for (int l = 0; l < DW; l++) begin
          if ($urandom_range(0, 2) != 0)
            setLane(l, $urandom_range(0, 2), $urandom_range(0, 15), 1'($urandom),
                    $urandom_range(0, 15), 1'($urandom));
        end
        for (int w = 0; w < WW; w++) begin
          if ($urandom_range(0, 1) != 0) setWake(w, $urandom_range(0, 15), $urandom);
        end
        fu_ready = 3'($urandom);
        flush    = ($urandom_range(0, 79) == 0);
        step();
      end
      if (pass == 0) doReset();
    end

    fu_ready = 3'b111;
    idleSteps(20);
    #1;
    for (int f = 0; f < IW; f++) chk("pending_issues", 64'(expIss[f].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
